uart_tx_drain: RTL and testbench
================================

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal range 2..65535.
REQ-002 The block SHALL have parameter PARITY_EN, default 0, meaning 1 inserts an even-parity bit after the data bits.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 tx_en  input  1  when 1, new frames may start; when 0, no new FIFO read is issued.
REQ-007 fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 fifo_data  input  8  upstream FIFO read data, valid the cycle after a read is accepted.
REQ-009 fifo_re  output  1  registered read strobe to the upstream FIFO; one-cycle pulse.
REQ-010 tx  output  1  registered serial line; idle level 1.
REQ-011 busy  output  1  1 in every state except IDLE.
REQ-012 frame_done  output  1  one-cycle pulse after the final stop-bit period ends.

Function
REQ-013 The FSM SHALL have the states IDLE, FETCH, START, DATA, PARITY, STOP.
REQ-014 IDLE: when tx_en=1 and fifo_empty=0, the block SHALL drive fifo_re=1 for exactly one cycle and move to FETCH.
REQ-015 FETCH: one cycle; the block SHALL capture fifo_data into an 8-bit shift register, compute even parity (XOR of the bits) and move to START.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles; a 3-bit index tracks the bit; after bit 7 the FSM goes to PARITY if PARITY_EN=1, else STOP.
REQ-018 PARITY: tx equals the XOR of the 8 data bits for CLKS_PER_BIT cycles, then STOP.
REQ-019 STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; frame_done=1 in the cycle after the final stop cycle, coincident with the return to IDLE.
REQ-020 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide (minimum 1), count 0..CLKS_PER_BIT-1 and clear on every state change.
REQ-021 tx SHALL be registered and change only at state or bit boundaries; it SHALL never glitch mid-bit.
REQ-022 Back-to-back frames: from the frame_done cycle (IDLE), if tx_en=1 and fifo_empty=0, fifo_re SHALL assert in that same cycle, giving exactly 2 idle-high cycles between stop end and next start.
REQ-023 fifo_re SHALL never assert when fifo_empty=1 or outside IDLE; at most one read per frame.
REQ-024 tx_en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next IDLE read.
REQ-025 fifo_empty rising during a frame SHALL have no effect on that frame.
REQ-026 Frame length SHALL be (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles from START entry to the STOP exit.

Reset
REQ-027 While rstn=0: tx=1, fifo_re=0, busy=0, frame_done=0, state=IDLE, counters, index and shift register =0.
REQ-028 Reset asserted mid-frame SHALL force tx=1 immediately (asynchronously); a byte already read from the FIFO is discarded, not retransmitted.
REQ-029 After rstn deasserts, the first fifo_re SHALL occur no earlier than the first rising edge at which rstn=1, tx_en=1 and fifo_empty=0.

Verification
REQ-030 CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds 0xA5 -> one fifo_re pulse; tx = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles); one frame_done pulse.
REQ-031 CLKS_PER_BIT=4, PARITY_EN=1, byte 0x07 -> parity bit 1, frame 44 cycles; byte 0x03 -> parity bit 0.
REQ-032 FIFO holds 0x11, 0x22 -> two frames separated by exactly 2 idle-high cycles; exactly 2 fifo_re pulses; data order preserved.
REQ-033 fifo_empty=1 held 100 cycles with tx_en=1 -> fifo_re never asserted, tx=1, busy=0.
REQ-034 tx_en dropped during DATA bit 3 -> frame completes normally, no further fifo_re until tx_en=1 again.
REQ-035 rstn pulsed low during DATA bit 5 -> tx=1 within the same cycle, busy=0; after release with a non-empty FIFO the next byte is read, not the aborted one.

Source files
------------

// File: rtl/uart_tx_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_drain
//
// Drains bytes from an upstream FIFO and serialises each one as an 8N1-style
// UART frame: start bit (0), eight data bits LSB first, an optional even
// parity bit, then one or two stop bits (1). The line idles high.
//
// Frame sequence: IDLE -> FETCH -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   IDLE   : issue a one-cycle FIFO read when tx_en=1 and the FIFO is not empty
//   FETCH  : capture the FIFO read data and its parity
//   START  : drive 0 for one bit period
//   DATA   : shift out 8 bits, LSB first
//   PARITY : drive the XOR of the data bits (only when PARITY_EN=1)
//   STOP   : drive 1 for STOP_BITS bit periods, then pulse frame_done
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (2..65535)
//   PARITY_EN    : 1 inserts an even-parity bit after the data bits
//   STOP_BITS    : stop bits per frame (1 or 2)
//
// Ports
//   clk        : clock, rising edge
//   rstn       : asynchronous active-low reset
//   tx_en      : allows a new frame to start; never aborts a frame in flight
//   fifo_empty : upstream FIFO empty flag
//   fifo_data  : upstream FIFO read data, sampled in FETCH
//   fifo_re    : registered one-cycle read strobe to the FIFO
//   tx         : registered serial output, idle high
//   busy       : 1 in every state except IDLE
//   frame_done : one-cycle pulse coincident with the return to IDLE
// -----------------------------------------------------------------------------
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_re,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  // Bit-period counter width; a 1-bit counter is the floor.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] PARITY = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;

  logic [2:0]       state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [2:0]       bit_idx_q,    bit_idx_d;
  logic             stop_idx_q,   stop_idx_d;
  logic [7:0]       shift_q,      shift_d;
  logic             parity_q,     parity_d;
  logic             tx_q,         tx_d;
  logic             fifo_re_q,    fifo_re_d;
  logic             frame_done_q, frame_done_d;

  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    fifo_re_d    = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_en && !fifo_empty) begin
          fifo_re_d = 1'b1;
          state_d   = FETCH;
        end
      end

      FETCH: begin
        shift_d  = fifo_data;
        parity_d = ^fifo_data;
        state_d  = START;
      end

      START: begin
        if (bit_end) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            stop_idx_d = 1'b0;
            state_d    = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            // The bit on the line is always shift_q[0]; shift at each bit end.
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          stop_idx_d = 1'b0;
          state_d    = STOP;
        end
      end

      STOP: begin
        if (bit_end) begin
          if (stop_idx_q == STOP_LAST) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // The counter only runs in the timed states and restarts at every bit
    // boundary and every state change.
    if (state_q == IDLE || state_q == FETCH || state_d != state_q || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // tx is computed from the next state so the register holds the new bit
    // value from the first cycle of each bit period and is constant within it.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      stop_idx_q   <= 1'b0;
      // NOTE: the shift register is a plain flop bank, not a RAM, so it can
      // and does take the reset like the rest of the datapath.
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      fifo_re_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      fifo_re_q    <= fifo_re_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_re    = fifo_re_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_drain.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_drain
//
// Directed bench for uart_tx_drain. Two instances share clk/rstn/tx_en:
//   u_dut0 : CLKS_PER_BIT=4, no parity, 1 stop bit
//   u_dut1 : CLKS_PER_BIT=4, even parity, 1 stop bit
// Each has its own small FIFO model (data valid while the strobe is high,
// popped on the edge that ends the strobe). The serial line is recorded cycle
// by cycle from the first start-bit cycle up to the frame_done cycle and
// compared with a waveform built from the byte.
// -----------------------------------------------------------------------------
module tb_uart_tx_drain;

  logic       clk = 1'b0;
  logic       rstn;
  logic       tx_en;

  logic       fifo_empty0, fifo_empty1;
  logic [7:0] fifo_data0,  fifo_data1;
  logic       fifo_re0,    fifo_re1;
  logic       tx0,         tx1;
  logic       busy0,       busy1;
  logic       frame_done0, frame_done1;

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [3:0] wr_ptr0 = '0, rd_ptr0 = '0;
  logic [3:0] wr_ptr1 = '0, rd_ptr1 = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int re_cnt0  = 0, re_cnt1 = 0;
  int fd_cnt0  = 0, fd_cnt1 = 0;
  int bad_re   = 0;

  always #5 clk = ~clk;

  uart_tx_drain #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rstn(rstn), .tx_en(tx_en), .fifo_empty(fifo_empty0),
    .fifo_data(fifo_data0), .fifo_re(fifo_re0), .tx(tx0), .busy(busy0),
    .frame_done(frame_done0)
  );

  uart_tx_drain #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .tx_en(tx_en), .fifo_empty(fifo_empty1),
    .fifo_data(fifo_data1), .fifo_re(fifo_re1), .tx(tx1), .busy(busy1),
    .frame_done(frame_done1)
  );

  // FIFO models
  assign fifo_empty0 = (wr_ptr0 == rd_ptr0);
  assign fifo_empty1 = (wr_ptr1 == rd_ptr1);
  assign fifo_data0  = mem0[rd_ptr0];
  assign fifo_data1  = mem1[rd_ptr1];

  always @(posedge clk) begin
    if (fifo_re0) rd_ptr0 <= rd_ptr0 + 4'd1;
    if (fifo_re1) rd_ptr1 <= rd_ptr1 + 4'd1;
  end

  // Event counters, sampled mid-cycle
  always @(negedge clk) begin
    if (fifo_re0)    re_cnt0 <= re_cnt0 + 1;
    if (fifo_re1)    re_cnt1 <= re_cnt1 + 1;
    if (frame_done0) fd_cnt0 <= fd_cnt0 + 1;
    if (frame_done1) fd_cnt1 <= fd_cnt1 + 1;
    if ((fifo_re0 && fifo_empty0) || (fifo_re1 && fifo_empty1)) bad_re <= bad_re + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push0(input logic [7:0] b);
    mem0[wr_ptr0] = b;
    wr_ptr0 = wr_ptr0 + 4'd1;
  endtask

  task automatic push1(input logic [7:0] b);
    mem1[wr_ptr1] = b;
    wr_ptr1 = wr_ptr1 + 4'd1;
  endtask

  function automatic logic tx_of(input int d);
    return (d == 0) ? tx0 : tx1;
  endfunction

  function automatic logic fd_of(input int d);
    return (d == 0) ? frame_done0 : frame_done1;
  endfunction

  // Expected line waveform, 4 cycles per bit, index 0 = first start-bit cycle.
  function automatic logic [63:0] exp_wave(input logic [7:0] b, input bit par_en);
    logic [11:0] f;
    logic [63:0] w;
    int          nb;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = b[k];
    if (par_en) f[9] = ^b;
    nb = par_en ? 11 : 10;
    w  = '0;
    for (int i = 0; i < nb * 4; i++) w[i] = f[i/4];
    return w;
  endfunction

  // Called at a negedge; waits for the start bit, then records tx every cycle
  // until frame_done. pre = idle-high cycles seen before the start bit.
  task automatic rx_frame(input int d, output logic [63:0] w, output int len, output int pre);
    w   = '0;
    len = 0;
    pre = 0;
    @(negedge clk);
    while (tx_of(d) !== 1'b0 && pre < 300) begin
      pre++;
      @(negedge clk);
    end
    while (fd_of(d) !== 1'b1 && len < 64) begin
      w[len] = tx_of(d);
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    int          len, pre, n, bad_idle, re_snap, fd_snap;

    rstn  = 1'b0;
    tx_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx",         tx0,         1'b1);
    check("rst_busy",       busy0,       1'b0);
    check("rst_fifo_re",    fifo_re0,    1'b0);
    check("rst_frame_done", frame_done0, 1'b0);
    rstn = 1'b1;

    // Empty FIFO with tx_en=1 for 100 cycles: nothing happens
    tx_en    = 1'b1;
    bad_idle = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || fifo_re0 !== 1'b0) bad_idle++;
    end
    check("idle_bad_cycles", bad_idle, 0);
    check("idle_re_count",   re_cnt0,  0);

    // Single frame 0xA5
    re_snap = re_cnt0;
    fd_snap = fd_cnt0;
    push0(8'hA5);
    rx_frame(0, w, len, pre);
    check("a5_wave", w,   exp_wave(8'hA5, 1'b0));
    check("a5_len",  len, 40);
    repeat (2) @(negedge clk);
    check("a5_re_pulses", re_cnt0 - re_snap, 1);
    check("a5_fd_pulses", fd_cnt0 - fd_snap, 1);

    // Back-to-back 0x11, 0x22
    re_snap = re_cnt0;
    push0(8'h11);
    push0(8'h22);
    rx_frame(0, w, len, pre);
    check("b2b_first_wave", w,   exp_wave(8'h11, 1'b0));
    check("b2b_first_len",  len, 40);
    rx_frame(0, w, len, pre);
    check("b2b_second_wave", w,       exp_wave(8'h22, 1'b0));
    check("b2b_idle_gap",    pre + 1, 2);
    repeat (2) @(negedge clk);
    check("b2b_re_pulses", re_cnt0 - re_snap, 2);

    // tx_en dropped during data bit 3: frame completes, no next read
    re_snap = re_cnt0;
    push0(8'h3C);
    push0(8'h5A);
    fork
      rx_frame(0, w, len, pre);
      begin
        n = 0;
        @(negedge clk);
        while (tx0 !== 1'b0 && n < 300) begin
          n++;
          @(negedge clk);
        end
        repeat (17) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    check("txen_drop_wave", w,   exp_wave(8'h3C, 1'b0));
    check("txen_drop_len",  len, 40);
    repeat (30) @(negedge clk);
    check("txen_drop_re_pulses", re_cnt0 - re_snap, 1);
    check("txen_drop_busy",      busy0,             1'b0);
    check("txen_drop_tx",        tx0,               1'b1);
    tx_en = 1'b1;
    rx_frame(0, w, len, pre);
    check("txen_resume_wave", w, exp_wave(8'h5A, 1'b0));
    repeat (2) @(negedge clk);

    // Reset during data bit 5: aborted byte is not resent
    re_snap = re_cnt0;
    fd_snap = fd_cnt0;
    push0(8'h96);
    push0(8'h4B);
    n = 0;
    @(negedge clk);
    while (tx0 !== 1'b0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    repeat (25) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("abort_tx",   tx0,   1'b1);
    check("abort_busy", busy0, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rx_frame(0, w, len, pre);
    check("abort_next_wave", w,   exp_wave(8'h4B, 1'b0));
    check("abort_next_len",  len, 40);
    repeat (2) @(negedge clk);
    check("abort_re_pulses", re_cnt0 - re_snap, 2);
    check("abort_fd_pulses", fd_cnt0 - fd_snap, 1);

    // Parity instance: 0x07 -> parity 1, 0x03 -> parity 0
    push1(8'h07);
    rx_frame(1, w, len, pre);
    check("par07_wave", w,     exp_wave(8'h07, 1'b1));
    check("par07_len",  len,   44);
    check("par07_bit",  w[38], 1'b1);
    push1(8'h03);
    rx_frame(1, w, len, pre);
    check("par03_wave", w,     exp_wave(8'h03, 1'b1));
    check("par03_len",  len,   44);
    check("par03_bit",  w[38], 1'b0);
    repeat (2) @(negedge clk);
    check("par_re_pulses", re_cnt1, 2);
    check("par_fd_pulses", fd_cnt1, 2);

    check("fifo_re_while_empty", bad_re, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
